// File: rtl/fifo_window_unpacker.sv
// rtl/fifo_window_unpacker.sv - byte-lane FIFO receiver that rebuilds a WORDS-sample tap window
// Optional feature macro: FIFO_WINDOW_CHECKSUM_EN (adds checksum / checksum_err outputs).
module fifo_window_unpacker #(
    parameter int WORDS = 64,
    localparam int DATA_W = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             load,
    input  logic                             valid,
    input  logic [7:0]                       A7,
    input  logic [7:0]                       A6,
    input  logic [7:0]                       A5,
    input  logic [7:0]                       A4,
    input  logic [7:0]                       A3,
    input  logic [7:0]                       A2,
    input  logic [7:0]                       A1,
    input  logic [7:0]                       A0,
    input  logic [$clog2(WORDS)-1:0]         rd_addr,
    output logic [DATA_W-1:0]                rd_data,
    output logic                             frame_done,
    output logic                             busy,
    output logic [$clog2(WORDS/4)-1:0]       beat_cnt,
    output logic                             err_abort
`ifdef FIFO_WINDOW_CHECKSUM_EN
    ,
    output logic [15:0]                      checksum,
    output logic                             checksum_err
`endif
);

    localparam int BEATS = WORDS / 4;
    localparam int AW    = $clog2(WORDS);
    localparam int BW    = $clog2(BEATS);

    typedef enum logic [1:0] {IDLE, COLLECT, COMMIT} state_t;

    state_t              state_q, state_d;
    logic [BW-1:0]       beat_q, beat_d;
    logic                err_q, err_d;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   stage_q  [WORDS];
    logic [DATA_W-1:0]   commit_q [WORDS];
    logic [DATA_W-1:0]   lane_w   [4];
    logic                accept;
    logic [BW-1:0]       beat_idx;

    assign lane_w[0] = {A1, A0};
    assign lane_w[1] = {A3, A2};
    assign lane_w[2] = {A5, A4};
    assign lane_w[3] = {A7, A6};

    // A load in IDLE or COLLECT always restarts the frame at beat 0.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        err_d    = err_q;
        accept   = 1'b0;
        beat_idx = beat_q;
        if (enable) begin
            unique case (state_q)
                IDLE, COLLECT: begin
                    if (load) begin
                        beat_idx = '0;
                        if (state_q == COLLECT) err_d = 1'b1;
                    end
                    if (load || state_q == COLLECT) begin
                        if (valid) begin
                            accept = 1'b1;
                            if (beat_idx == BW'(BEATS - 1)) begin
                                state_d = COMMIT;
                                beat_d  = '0;
                            end else begin
                                state_d = COLLECT;
                                beat_d  = beat_idx + 1'b1;
                            end
                        end else begin
                            state_d = COLLECT;
                            beat_d  = beat_idx;
                        end
                    end
                end
                COMMIT: begin
                    if (load) err_d = 1'b1;
                    state_d = IDLE;
                    beat_d  = '0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
            for (int i = 0; i < WORDS; i++) begin
                stage_q[i]  <= '0;
                commit_q[i] <= '0;
            end
        end else if (enable) begin
            state_q <= state_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            rd_q    <= commit_q[rd_addr];
            if (accept) begin
                for (int k = 0; k < 4; k++) stage_q[{beat_idx, 2'(k)}] <= lane_w[k];
            end
            if (state_q == COMMIT) begin
                for (int i = 0; i < WORDS; i++) commit_q[i] <= stage_q[i];
            end
        end
    end

    assign rd_data    = rd_q;
    assign frame_done = enable && (state_q == COMMIT);
    assign busy       = (state_q == COLLECT);
    assign beat_cnt   = beat_q;
    assign err_abort  = err_q;

`ifdef FIFO_WINDOW_CHECKSUM_EN
    logic [15:0] sum_q, sum_d, cks_q;
    logic        last_beat;

    // The final word of the frame carries the transmitted sum, so it is left out.
    assign last_beat = (beat_idx == BW'(BEATS - 1));

    always_comb begin
        sum_d = sum_q;
        if (enable && load && state_q != COMMIT) sum_d = '0;
        if (accept) sum_d = sum_d + lane_w[0] + lane_w[1] + lane_w[2] + (last_beat ? 16'd0 : lane_w[3]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q <= '0;
            cks_q <= '0;
        end else if (enable) begin
            sum_q <= sum_d;
            if (state_q == COMMIT) cks_q <= sum_q;
        end
    end

    assign checksum     = cks_q;
    assign checksum_err = frame_done && (sum_q != stage_q[AW'(WORDS - 1)]);
`endif

endmodule

// File: tb/tb_fifo_window_unpacker.sv
// tb/tb_fifo_window_unpacker.sv - scoreboard bench for fifo_window_unpacker
module tb_fifo_window_unpacker;
    localparam int WORDS = 64;
    localparam int BEATS = WORDS / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        load = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  a [8];
    logic [5:0]  rd_addr = '0;
    logic [15:0] rd_data;
    logic        frame_done, busy, err_abort;
    logic [3:0]  beat_cnt;
`ifdef FIFO_WINDOW_CHECKSUM_EN
    logic [15:0] checksum;
    logic        checksum_err;
`endif

    fifo_window_unpacker #(.WORDS(WORDS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .valid(valid),
        .A7(a[7]), .A6(a[6]), .A5(a[5]), .A4(a[4]),
        .A3(a[3]), .A2(a[2]), .A1(a[1]), .A0(a[0]),
        .rd_addr(rd_addr), .rd_data(rd_data), .frame_done(frame_done),
        .busy(busy), .beat_cnt(beat_cnt), .err_abort(err_abort)
`ifdef FIFO_WINDOW_CHECKSUM_EN
        , .checksum(checksum), .checksum_err(checksum_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct packed { int cyc; logic ce; } done_t;
    logic [15:0] rd_exp_q [$];
    done_t       done_q [$];
    logic        rd_req = 1'b0;
    logic        rd_pend = 1'b0;
    logic [15:0] mon_e;
    done_t       mon_d;

    always @(posedge clk) rd_pend <= rd_req && enable && !reset;

    always @(negedge clk) begin
        if (rd_pend) begin
            if (rd_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: read with no expected value (cycle %0d)", cyc);
            end else begin
                mon_e = rd_exp_q.pop_front();
                chk("rd_data", rd_data, mon_e);
            end
        end
        if (frame_done === 1'b1) begin
            if (done_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL frame_done_unexpected: pulse at cycle %0d", cyc);
            end else begin
                mon_d = done_q.pop_front();
                chk("frame_done_cycle", cyc, mon_d.cyc);
`ifdef FIFO_WINDOW_CHECKSUM_EN
                chk("checksum_err", checksum_err, mon_d.ce);
`endif
            end
        end
    end

    logic [7:0] fb [128];

    function automatic logic [15:0] wd(input int i);
        return {fb[2*i+1], fb[2*i]};
    endfunction

    function automatic logic model_ce();
        logic [15:0] s;
        s = '0;
        for (int i = 0; i < WORDS - 1; i++) s = s + wd(i);
        return s != wd(WORDS - 1);
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < 128; i++) fb[i] = 8'(i);
    endtask

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < 128; i++) fb[i] = v;
    endtask

    task automatic fill_cks(input logic [15:0] last);
        for (int i = 0; i < WORDS; i++) begin
            fb[2*i]   = 8'h01;
            fb[2*i+1] = 8'h00;
        end
        fb[126] = last[7:0];
        fb[127] = last[15:8];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input int b);
        for (int k = 0; k < 8; k++) a[k] = fb[8*b+k];
    endtask

    task automatic rd(input logic [5:0] addr, input logic [15:0] exp);
        rd_addr = addr;
        rd_req  = 1'b1;
        rd_exp_q.push_back(exp);
        step();
        rd_req = 1'b0;
    endtask

    task automatic send_partial(input int n);
        for (int b = 0; b < n; b++) begin
            load = (b == 0);
            valid = 1'b1;
            set_lanes(b);
            step();
        end
        load = 1'b0;
        valid = 1'b0;
    endtask

    // rd_a >= 0: read that address during the back half and the COMMIT cycle, expecting rd_old.
    // pause_b >= 1: hold enable low for 5 cycles before that beat, expecting rd_data == held.
    task automatic send_frame(input int rd_a, input logic [15:0] rd_old,
                              input int pause_b, input logic [15:0] held, input bit bubbles);
        done_t d;
        for (int b = 0; b < BEATS; b++) begin
            if (b == pause_b) begin
                enable = 1'b0; load = 1'b1; valid = 1'b1; rd_req = 1'b0; rd_addr = 6'd63;
                repeat (5) begin
                    step();
                    chk("hold_beat_cnt", beat_cnt, b);
                    chk("hold_rd_data", rd_data, held);
                end
                enable = 1'b1;
            end
            load = (b == 0);
            valid = 1'b1;
            set_lanes(b);
            if (rd_a >= 0 && b >= BEATS / 2) begin
                rd_addr = 6'(rd_a);
                rd_req = 1'b1;
                rd_exp_q.push_back(rd_old);
            end
            if (b == BEATS - 1) begin
                d.cyc = cyc + 1;
                d.ce = model_ce();
                done_q.push_back(d);
            end
            step();
            load = 1'b0;
            rd_req = 1'b0;
            chk("beat_cnt", beat_cnt, (b + 1) % BEATS);
            chk("busy", busy, b != BEATS - 1);
            if (bubbles && b != BEATS - 1) begin
                valid = 1'b0;
                step();
                chk("bubble_beat_cnt", beat_cnt, b + 1);
            end
        end
        valid = 1'b0;
        if (rd_a >= 0) begin
            rd_addr = 6'(rd_a);
            rd_req = 1'b1;
            rd_exp_q.push_back(rd_old);
        end
        step();
        rd_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 8; k++) a[k] = '0;
        repeat (2) step();
        reset = 1'b0;
        chk("reset_rd_data", rd_data, 0);
        chk("reset_frame_done", frame_done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_beat_cnt", beat_cnt, 0);
        chk("reset_err_abort", err_abort, 0);

        fill_ramp();
        send_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        rd(6'd0, 16'h0100);
        rd(6'd1, 16'h0302);
        rd(6'd63, 16'h7F7E);

        send_frame(-1, 16'h0, -1, 16'h0, 1'b1);
        rd(6'd5, 16'h0B0A);
        rd(6'd62, 16'h7D7C);

        fill_const(8'h11);
        send_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        rd(6'd5, 16'h1111);
        fill_const(8'h22);
        send_frame(5, 16'h1111, -1, 16'h0, 1'b0);
        rd(6'd5, 16'h2222);
        chk("no_abort_yet", err_abort, 0);

        fill_const(8'h44);
        send_partial(7);
        chk("partial_beat_cnt", beat_cnt, 7);
        fill_ramp();
        send_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        chk("err_abort_sticky", err_abort, 1);
        rd(6'd0, 16'h0100);
        rd(6'd10, 16'h1514);
        rd(6'd63, 16'h7F7E);

        rd(6'd10, 16'h1514);
        fill_const(8'h66);
        send_frame(-1, 16'h0, 8, 16'h1514, 1'b0);
        rd(6'd63, 16'h6666);
        rd(6'd0, 16'h6666);
        chk("err_abort_still_set", err_abort, 1);

        fill_const(8'h77);
        send_partial(10);
        chk("pre_reset_beat_cnt", beat_cnt, 10);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midreset_rd_data", rd_data, 0);
        chk("midreset_frame_done", frame_done, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_beat_cnt", beat_cnt, 0);
        chk("midreset_err_abort", err_abort, 0);
        rd(6'd0, 16'h0000);
        rd(6'd33, 16'h0000);
        rd(6'd63, 16'h0000);

`ifdef FIFO_WINDOW_CHECKSUM_EN
        fill_cks(16'h003F);
        send_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        chk("checksum_good", checksum, 16'h003F);
        fill_cks(16'h0040);
        send_frame(-1, 16'h0, -1, 16'h0, 1'b0);
        chk("checksum_bad", checksum, 16'h003F);
`endif

        repeat (3) step();
        chk("rd_queue_empty", rd_exp_q.size(), 0);
        chk("done_queue_empty", done_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
